bram2axis: RTL and testbench

- Frame-buffer reader; the read-side counterpart of the stream-to-BRAM writer.
- On a start pulse it walks one full frame of the native BRAM read port, addresses 0 to FRAME_PIX-1.
- It emits each pixel as an AXI4-Stream beat, with TLAST at each line end.
- It feeds the filter/display path from stored frames (replay, test-pattern injection, VGA/HDMI stream front end).

---
 rtl/video_pkg.sv | 17 +
 rtl/axis_skid_fifo.sv | 43 ++++
 rtl/bram2axis.sv | 121 ++++++++++++
 tb/tb_bram2axis.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared frame geometry, RGB555 pixel and stream-beat types.
// beat_t carries the start-of-frame bit only when BRAM2AXIS_SOF_EN is defined.
package video_pkg;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
   localparam int ADDR_W = 19;
   localparam int PIX_W = 15;
   typedef logic [PIX_W-1:0] pixel_t;
   typedef struct packed {
      pixel_t data;
      logic last;
`ifdef BRAM2AXIS_SOF_EN
      logic sof;
`endif
   } beat_t;
endpackage

// File: rtl/axis_skid_fifo.sv
// axis_skid_fifo: 2-entry FIFO of beat_t with occupancy count.
// Push and pop in the same cycle are allowed and leave the count unchanged.
module axis_skid_fifo
   import video_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  beat_t      din,
   input  logic       pop,
   output beat_t      dout,
   output logic [1:0] count
);
   beat_t mem_q [2];
   beat_t mem_d [2];
   logic rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [1:0] count_q, count_d;
   logic do_push, do_pop;
   always_comb begin
      do_pop = pop && count_q != 2'd0;
      do_push = push && (count_q != 2'd2 || do_pop);
      mem_d = mem_q;
      if (do_push) mem_d[wr_ptr_q] = din;
      wr_ptr_d = wr_ptr_q ^ do_push;
      rd_ptr_d = rd_ptr_q ^ do_pop;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '{default: '0};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
      end
   end
   assign dout = mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: rtl/bram2axis.sv
// bram2axis: walks one frame of BRAM on start and streams it as AXI4-Stream with TLAST per line.
// Defining BRAM2AXIS_SOF_EN adds m_tuser, high on the first beat of each frame.
module bram2axis
   import video_pkg::*;
#(
   parameter int H_ACTIVE = video_pkg::H_ACTIVE,
   parameter int V_ACTIVE = video_pkg::V_ACTIVE,
   parameter int ADDR_W = video_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              RESETn,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  pixel_t            rd_data,
   output logic [15:0]       m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
`ifdef BRAM2AXIS_SOF_EN
   output logic              m_tuser,
`endif
   output logic              m_tlast
);
   localparam int XW = $clog2(H_ACTIVE);
   localparam int YW = $clog2(V_ACTIVE);
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic inflight_q, last_q, done_q, done_d;
   logic pop, x_end, fin;
   logic [1:0] count;
   beat_t din, head;
`ifdef BRAM2AXIS_SOF_EN
   logic sof_q;
`endif
   // Credit counts the beat leaving this cycle so a steady stream never bubbles.
   always_comb begin
      pop = m_tvalid && m_tready;
      x_end = x_q == XW'(H_ACTIVE - 1);
      fin = x_end && y_q == YW'(V_ACTIVE - 1);
      rd_en = state_q == FETCH && ({1'b0, count} + 3'(inflight_q)) < (3'd2 + 3'(pop));
      state_d = state_q;
      addr_d = addr_q;
      x_d = x_q;
      y_d = y_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = FETCH;
            addr_d = '0;
            x_d = '0;
            y_d = '0;
         end
         FETCH: if (rd_en) begin
            addr_d = fin ? addr_q : addr_q + 1'b1;
            x_d = x_end ? '0 : x_q + 1'b1;
            y_d = x_end ? y_q + 1'b1 : y_q;
            state_d = fin ? DRAIN : FETCH;
         end
         DRAIN: begin
            done_d = pop && count == 2'd1 && !inflight_q;
            state_d = done_q ? IDLE : DRAIN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= IDLE;
         addr_q <= '0;
         x_q <= '0;
         y_q <= '0;
         inflight_q <= 1'b0;
         last_q <= 1'b0;
         done_q <= 1'b0;
`ifdef BRAM2AXIS_SOF_EN
         sof_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         x_q <= x_d;
         y_q <= y_d;
         inflight_q <= rd_en;
         last_q <= x_end;
         done_q <= done_d;
`ifdef BRAM2AXIS_SOF_EN
         sof_q <= addr_q == '0;
`endif
      end
   end
   always_comb begin
      din.data = rd_data;
      din.last = last_q;
`ifdef BRAM2AXIS_SOF_EN
      din.sof = sof_q;
`endif
   end
   axis_skid_fifo u_fifo (
      .clk   (clk),
      .rst_n (RESETn),
      .push  (inflight_q),
      .din   (din),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );
   assign busy = state_q != IDLE;
   assign done = done_q;
   assign rd_addr = addr_q;
   assign m_tvalid = count != 2'd0;
   assign m_tdata = {1'b0, head.data};
   assign m_tlast = head.last;
`ifdef BRAM2AXIS_SOF_EN
   assign m_tuser = head.sof;
`endif
endmodule

// File: tb/tb_bram2axis.sv
// tb_bram2axis: directed checks of bram2axis on a 4x3 frame with BRAM data equal to address.
module tb_bram2axis;
   localparam int H = 4;
   localparam int V = 3;
   logic clk = 1'b0, RESETn = 1'b0, start = 1'b0, m_tready = 1'b0;
   logic busy, done, rd_en, m_tvalid, m_tlast;
   logic [18:0] rd_addr;
   logic [14:0] rd_data = '0;
   logic [15:0] m_tdata;
`ifdef BRAM2AXIS_SOF_EN
   logic m_tuser;
`endif
   int n_vec = 0, n_err = 0;
   always #5 clk = ~clk;
   always @(posedge clk) if (rd_en) rd_data <= rd_addr[14:0];
   bram2axis #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .clk      (clk),
      .RESETn   (RESETn),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .m_tdata  (m_tdata),
      .m_tvalid (m_tvalid),
      .m_tready (m_tready),
`ifdef BRAM2AXIS_SOF_EN
      .m_tuser  (m_tuser),
`endif
      .m_tlast  (m_tlast)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask
   initial begin
      int n_rd, n_done, n_beats, n_last, exp_pix;
      logic held;
      logic [15:0] prev;
      // reset state
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_tdata", m_tdata, 0);
      RESETn = 1'b1;
      m_tready = 1'b1;
      tick();
      // basic frame: beat j appears in cycle 3+j, done in cycle 15
      go();
      chk("c1_busy", busy, 1);
      chk("c1_rd_en", rd_en, 1);
      chk("c1_addr", rd_addr, 0);
      tick();
      chk("c2_tvalid", m_tvalid, 0);
      chk("c2_addr", rd_addr, 1);
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("basic_valid", m_tvalid, 1);
         chk("basic_data", m_tdata, j);
         chk("basic_last", m_tlast, (j % 4) == 3);
         chk("basic_done", done, 0);
`ifdef BRAM2AXIS_SOF_EN
         chk("basic_tuser", m_tuser, j == 0);
`endif
      end
      tick();
      chk("c15_done", done, 1);
      chk("c15_busy", busy, 1);
      chk("c15_tvalid", m_tvalid, 0);
      chk("addr_max", rd_addr, 11);
      tick();
      chk("c16_done", done, 0);
      chk("c16_busy", busy, 0);
      // ready low: only two reads issue, head held
      m_tready = 1'b0;
      go();
      n_rd = 0;
      for (int i = 0; i < 20; i++) begin
         n_rd += int'(rd_en);
         if (i >= 2) chk("stall_head", {m_tvalid, m_tdata}, {1'b1, 16'd0});
         tick();
      end
      chk("stall_issues", n_rd, 2);
      chk("stall_count", dut.u_fifo.count_q, 2);
      m_tready = 1'b1;
      for (int j = 0; j < 12; j++) begin
         chk("release_valid", m_tvalid, 1);
         chk("release_data", m_tdata, j);
         tick();
      end
      chk("release_done", done, 1);
      tick();
      chk("release_idle", busy, 0);
      // start mid-frame and in the done cycle are ignored
      go();
      n_done = 0;
      n_beats = 0;
      for (int c = 1; c <= 17; c++) begin
         start = (c == 8 || c == 15);
         if (c == 8) chk("restart_busy", busy, 1);
         if (c == 15) chk("restart_done_cycle", done, 1);
         if (c == 16) chk("restart_ignored", busy, 0);
         n_done += int'(done);
         n_beats += int'(m_tvalid && m_tready);
         tick();
      end
      start = 1'b0;
      chk("restart_ndone", n_done, 1);
      chk("restart_beats", n_beats, 12);
      chk("restart_idle", busy, 0);
      // random backpressure
      go();
      exp_pix = 0;
      n_last = 0;
      n_done = 0;
      held = 1'b0;
      prev = '0;
      for (int c = 0; c < 400 && n_done == 0; c++) begin
         m_tready = 1'($urandom_range(0, 1));
         if (held) chk("rand_stable", {m_tvalid, m_tdata}, {1'b1, prev});
         if (m_tvalid && m_tready) begin
            chk("rand_data", m_tdata, exp_pix);
            chk("rand_last", m_tlast, (exp_pix % 4) == 3);
            n_last += int'(m_tlast);
            exp_pix++;
         end
         held = m_tvalid && !m_tready;
         prev = m_tdata;
         n_done += int'(done);
         tick();
      end
      chk("rand_beats", exp_pix, 12);
      chk("rand_lasts", n_last, 3);
      chk("rand_done", n_done, 1);
      // asynchronous reset mid-frame, then a clean restart
      m_tready = 1'b1;
      tick();
      go();
      repeat (7) tick();
      chk("pre_rst_data", m_tdata, 5);
      #2 RESETn = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_rd_en", rd_en, 0);
      chk("arst_tvalid", m_tvalid, 0);
      chk("arst_tdata", m_tdata, 0);
      chk("arst_rd_addr", rd_addr, 0);
      chk("arst_tlast", m_tlast, 0);
      chk("arst_done", done, 0);
      tick();
      RESETn = 1'b1;
      n_done = 0;
      for (int i = 0; i < 5; i++) begin
         n_done += int'(done);
         tick();
      end
      chk("arst_no_done", n_done, 0);
      go();
      tick();
      tick();
      chk("post_rst_valid", m_tvalid, 1);
      chk("post_rst_data0", m_tdata, 0);
`ifdef BRAM2AXIS_SOF_EN
      chk("post_rst_tuser0", m_tuser, 1);
`endif
      tick();
      chk("post_rst_data1", m_tdata, 1);
`ifdef BRAM2AXIS_SOF_EN
      chk("post_rst_tuser1", m_tuser, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
